path_metric_register: RTL and testbench

PATH_METRIC_REGISTER -- requirements
Module: path_metric_register

---
 rtl/path_metric_register.sv | 109 ++++++++++
 tb/tb_path_metric_register.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/path_metric_register.sv
// Path metric register for a 4-state Viterbi ACS loop: holds the metrics for one frame and reports the best final state.
// Optional macro PM_NORMALIZE_EN subtracts the minimum incoming metric before each capture.
module path_metric_register #(
   parameter int FRAME_LEN = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_valid,
   input  logic [1:0] i_PM_0,
   input  logic [1:0] i_PM_1,
   input  logic [1:0] i_PM_2,
   input  logic [1:0] i_PM_3,
   output logic [1:0] o_PM_0,
   output logic [1:0] o_PM_1,
   output logic [1:0] o_PM_2,
   output logic [1:0] o_PM_3,
   output logic       o_busy,
   output logic [7:0] o_step_cnt,
   output logic       o_done,
   output logic [1:0] o_best_state,
   output logic [1:0] o_best_PM
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] LAST_STEP = 8'(FRAME_LEN - 1);

   state_t     state;
   logic [1:0] n_0, n_1, n_2, n_3;
   logic [1:0] best_s, best_v;

`ifdef PM_NORMALIZE_EN
   logic [1:0] min_01, min_23, min_all;
   assign min_01  = (i_PM_1 < i_PM_0) ? i_PM_1 : i_PM_0;
   assign min_23  = (i_PM_3 < i_PM_2) ? i_PM_3 : i_PM_2;
   assign min_all = (min_23 < min_01) ? min_23 : min_01;
   assign n_0 = i_PM_0 - min_all;
   assign n_1 = i_PM_1 - min_all;
   assign n_2 = i_PM_2 - min_all;
   assign n_3 = i_PM_3 - min_all;
`else
   assign n_0 = i_PM_0;
   assign n_1 = i_PM_1;
   assign n_2 = i_PM_2;
   assign n_3 = i_PM_3;
`endif

   // Strict less-than so that ties keep the lowest index.
   always_comb begin
      best_s = 2'd0;
      best_v = n_0;
      if (n_1 < best_v) begin best_s = 2'd1; best_v = n_1; end
      if (n_2 < best_v) begin best_s = 2'd2; best_v = n_2; end
      if (n_3 < best_v) begin best_s = 2'd3; best_v = n_3; end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         o_PM_0       <= 2'd0;
         o_PM_1       <= 2'd3;
         o_PM_2       <= 2'd3;
         o_PM_3       <= 2'd3;
         o_step_cnt   <= 8'd0;
         o_done       <= 1'b0;
         o_busy       <= 1'b0;
         o_best_state <= 2'd0;
         o_best_PM    <= 2'd0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state      <= RUN;
                  o_busy     <= 1'b1;
                  o_step_cnt <= 8'd0;
               end
            end
            RUN: begin
               if (i_valid) begin
                  o_PM_0     <= n_0;
                  o_PM_1     <= n_1;
                  o_PM_2     <= n_2;
                  o_PM_3     <= n_3;
                  o_step_cnt <= o_step_cnt + 8'd1;
                  if (o_step_cnt == LAST_STEP) begin
                     state        <= DONE;
                     o_busy       <= 1'b0;
                     o_done       <= 1'b1;
                     o_best_state <= best_s;
                     o_best_PM    <= best_v;
                  end
               end
            end
            DONE: begin
               // Metrics go back to the known-start vector ready for the next frame.
               state  <= IDLE;
               o_PM_0 <= 2'd0;
               o_PM_1 <= 2'd3;
               o_PM_2 <= 2'd3;
               o_PM_3 <= 2'd3;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_path_metric_register.sv
// Randomized self-checking bench for path_metric_register with a frame-level reference model.
// Compile with +define+PM_NORMALIZE_EN to exercise the normalizing build.
module tb_path_metric_register;

   localparam int FL = 8;
`ifdef PM_NORMALIZE_EN
   localparam bit NORM = 1'b1;
`else
   localparam bit NORM = 1'b0;
`endif

   logic       clk, rst_n, start, valid;
   logic [1:0] pin [4];
   logic [1:0] pm0, pm1, pm2, pm3, best_s, best_pm;
   logic [7:0] cnt;
   logic       busy, done;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // Reference model state
   bit m_run  = 0;
   bit m_done = 0;
   int m_pm [4] = '{0, 3, 3, 3};
   int m_cnt = 0;
   int m_bs  = 0;
   int m_bp  = 0;

   path_metric_register #(.FRAME_LEN(FL)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
      .i_PM_0(pin[0]), .i_PM_1(pin[1]), .i_PM_2(pin[2]), .i_PM_3(pin[3]),
      .o_PM_0(pm0), .o_PM_1(pm1), .o_PM_2(pm2), .o_PM_3(pm3),
      .o_busy(busy), .o_step_cnt(cnt), .o_done(done),
      .o_best_state(best_s), .o_best_PM(best_pm)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int min4(input logic [1:0] v [4]);
      int m = 3;
      for (int k = 0; k < 4; k++) if (int'(v[k]) < m) m = int'(v[k]);
      return m;
   endfunction

   function automatic int argmin4(input logic [1:0] v [4]);
      int idx = 0;
      for (int k = 1; k < 4; k++) if (v[k] < v[idx]) idx = k;
      return idx;
   endfunction

   // Frame-level behaviour: a frame accepts FL valid vectors, then reports once and restarts from {0,3,3,3}.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 0; m_done <= 0; m_cnt <= 0; m_bs <= 0; m_bp <= 0;
         m_pm  <= '{0, 3, 3, 3};
      end else if (m_done) begin
         m_done <= 0;
         m_pm   <= '{0, 3, 3, 3};
      end else if (!m_run) begin
         if (start) begin m_run <= 1; m_cnt <= 0; end
      end else if (valid) begin
         for (int k = 0; k < 4; k++) m_pm[k] <= int'(pin[k]) - (NORM ? min4(pin) : 0);
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == FL) begin
            m_run  <= 0;
            m_done <= 1;
            m_bs   <= argmin4(pin);
            m_bp   <= NORM ? 0 : min4(pin);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pm0", pm0, m_pm[0]);
         chk("pm1", pm1, m_pm[1]);
         chk("pm2", pm2, m_pm[2]);
         chk("pm3", pm3, m_pm[3]);
         chk("step_cnt", cnt, m_cnt);
         chk("busy", busy, m_run);
         chk("done", done, m_done);
         chk("best_state", best_s, m_bs);
         chk("best_pm", best_pm, m_bp);
      end
   end

   task automatic drive(input bit s, input bit v, input int a, input int b, input int c, input int d);
      @(negedge clk); #2;
      start = s; valid = v;
      pin[0] = 2'(a); pin[1] = 2'(b); pin[2] = 2'(c); pin[3] = 2'(d);
   endtask

   task automatic drive_rand_valid();
      drive(0, 1, $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
   endtask

   initial begin
      rst_n = 0; start = 0; valid = 0;
      for (int k = 0; k < 4; k++) pin[k] = 2'd0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      #1;
      chk("rst_pm0", pm0, 0); chk("rst_pm1", pm1, 3); chk("rst_pm3", pm3, 3);
      chk("rst_cnt", cnt, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
      @(negedge clk); #2 rst_n = 1;

      // Full frame of {1,2,3,2}
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < FL; i++) drive(0, 1, 1, 2, 3, 2);
      @(negedge clk); #1;
      chk("frame_done", done, 1); chk("frame_cnt", cnt, 8);
      chk("frame_best_state", best_s, 0); chk("frame_best_pm", best_pm, NORM ? 0 : 1);
      #1 valid = 0;
      @(negedge clk); #1;
      chk("done_one_cycle", done, 0); chk("idle_pm1", pm1, 3); chk("hold_cnt", cnt, 8);

      // Tie on the final step, with a gap between every valid
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < FL - 1; i++) begin
         drive_rand_valid();
         drive(0, 0, 3, 3, 3, 3);
      end
      drive(0, 1, 3, 1, 1, 2);
      @(negedge clk); #1;
      chk("tie_best_state", best_s, 1); chk("tie_best_pm", best_pm, NORM ? 0 : 1);
      #1 valid = 0;

      // Capture check, start during RUN, valid in IDLE/DONE
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 2, 3, 2, 3);
      @(negedge clk); #1;
      chk("cap_pm0", pm0, NORM ? 0 : 2); chk("cap_pm1", pm1, NORM ? 1 : 3);
      chk("cap_pm2", pm2, NORM ? 0 : 2); chk("cap_pm3", pm3, NORM ? 1 : 3);
      #1 valid = 0;
      drive(1, 0, 1, 1, 1, 1);
      for (int i = 0; i < FL - 1; i++) drive_rand_valid();
      repeat (3) drive_rand_valid();
      drive(0, 0, 0, 0, 0, 0);

      // Reset mid-frame
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive_rand_valid();
      @(negedge clk); #2 rst_n = 0; valid = 0;
      #1;
      chk("mid_rst_pm0", pm0, 0); chk("mid_rst_pm2", pm2, 3);
      chk("mid_rst_cnt", cnt, 0); chk("mid_rst_done", done, 0);
      @(negedge clk); #2 rst_n = 1;
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < FL; i++) drive_rand_valid();
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(199) == 0) begin
            @(negedge clk); #2 rst_n = 0;
            @(negedge clk); #2 rst_n = 1;
         end else begin
            drive($urandom_range(7) == 0, $urandom_range(1) == 1,
                  $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
